demux_frame_driver: RTL
=======================

# demux_frame_driver

Upstream feeder for the 1-to-8 demultiplexer. Accepts a 1-bit serial stream under a valid/ready handshake. Each frame is a 3-bit channel header followed by a fixed-length payload. The block latches the header into the demux select and replays the payload bits on the demux data input, one per cycle, while the select is held stable. Frames addressed to masked channels are consumed and discarded.

## Interface
- PAYLOAD_BITS, 8, payload bits per frame; legal range 1..256.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- s_valid  input  1  serial bit valid.
- s_data  input  1  serial bit; header MSB first, then payload in arrival order.
- s_ready  output  1  block can accept a bit this cycle.
- chan_mask  input  8  bit n = 1 enables channel n; sampled at header completion.
- sel  output  3  demux select (registered).
- dout  output  1  demux data input (registered).
- active  output  1  dout carries a valid payload bit this cycle.
- frame_done  output  1  1-cycle pulse with the last payload bit of a delivered frame.
- frame_drop  output  1  1-cycle pulse when a masked frame finishes being consumed.

## Operation
- Transfer: a bit is accepted when s_valid && s_ready. No accept means no state change, except leaving GAP.
- FSM states:
  - HDR: s_ready=1. Uses hdr_cnt (2 bits). Bits 1 and 2 are shifted into hdr_q. On the 3rd accepted bit:
    - sel <= {hdr_q[1:0], s_data}.
    - en_q <= chan_mask[{hdr_q[1:0], s_data}].
    - pay_cnt <= 0.
    - Go to DATA.
  - DATA: s_ready=1. On each accepted bit:
    - dout <= s_data & en_q.
    - active <= en_q.
    - pay_cnt <= pay_cnt+1.
    - On the accept with pay_cnt == PAYLOAD_BITS-1: frame_done <= en_q, frame_drop <= ~en_q, go to GAP.
  - GAP: s_ready=0 for exactly one cycle, then go to HDR with hdr_cnt=0.
- Any cycle without an accepted payload bit: dout <= 0, active <= 0. During a stall the demux therefore sees in=0.
- sel holds its value outside header completion. It changes only on the edge after the 3rd header bit, never while active=1.
- pay_cnt width is $clog2(PAYLOAD_BITS+1). No wrap occurs because it is cleared at every header.
- When chan_mask is changed mid-frame, it does not affect the frame in flight.
- Frames are strictly sequential. No abort mechanism exists other than rst.

## Timing
- Reset values (edge with rst=1, visible the next cycle):
  - state=HDR, hdr_cnt=0, hdr_q=0, pay_cnt=0, en_q=0.
  - sel=0, dout=0, active=0, frame_done=0, frame_drop=0.
  - s_ready=1 from the first cycle after reset.
- Reset mid-frame discards the partial header or payload. The next accepted bit is treated as header MSB.
- s_ready is combinational from state only. It never depends on s_valid.
- Latency:
  - Header bit 3 accepted in cycle t: new sel is visible in cycle t+1.
  - Payload bit accepted in cycle t: dout/active are visible in cycle t+1.
- Minimum frame period with continuous valid: 3 + PAYLOAD_BITS + 1 cycles.
- frame_done/frame_drop assert in the cycle after the final payload accept, coincident with the last dout bit. They are high for exactly 1 cycle.
- s_valid held high during GAP: no accept occurs. The held bit is accepted in the following HDR cycle.
- Stall inside the header: hdr_cnt and hdr_q hold. The header completes on the 3rd accept regardless of gaps.

## Test plan
- Reset and idle:
  - Stimulus: rst for 2 cycles, then s_valid=0 for 10 cycles.
  - Required: sel=0, dout=0, active=0, frame_done=0, frame_drop=0 throughout; s_ready=1 after reset.
- Back-to-back frames (PAYLOAD_BITS=8, chan_mask=8'hFF, s_valid=1):
  - Stimulus: frame ch5 (bits 1,0,1), payload 1,0,1,1,0,0,1,0, then frame ch2.
  - Required: sel=5 at cycle 3; dout=1,0,1,1,0,0,1,0 with active=1 in cycles 4..11; frame_done at cycle 11; s_ready=0 at cycle 11; sel=2 at cycle 15.
- Stalls:
  - Stimulus: same ch5 frame with s_valid dropped for 2 cycles after header bit 1 and for 3 cycles after payload bit 4.
  - Required: sel=5 is delayed accordingly; active=0 and dout=0 during the stall gaps; payload order is preserved; exactly one frame_done.
- Masked channel:
  - Stimulus: chan_mask=8'hDF, frame to ch5 with payload 8'hFF.
  - Required: sel=5; active=0 and dout=0 for the whole payload; frame_drop pulses once; frame_done stays 0; the next frame to ch0 is delivered normally.
- Reset mid-payload:
  - Stimulus: rst asserted after payload bit 4 of a ch7 frame, then a clean ch1 frame.
  - Required: all outputs zero the cycle after reset; the ch1 frame is delivered intact with sel=1.
- Boundary (PAYLOAD_BITS=1):
  - Stimulus: frames to ch0 and ch7, each with a single payload bit 1.
  - Required: each frame shows one dout=1 cycle with active=1 and frame_done=1 together; frame period is 5 cycles.

Source files
------------

// File: rtl/demux_frame_driver.sv
// Serial-to-demux feeder: latches a 3-bit channel header into sel, then replays the
// payload bits on dout one per accepted cycle; frames to masked channels are swallowed.
module demux_frame_driver #(
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic       s_data,
  output logic       s_ready,
  input  logic [7:0] chan_mask,
  output logic [2:0] sel,
  output logic       dout,
  output logic       active,
  output logic       frame_done,
  output logic       frame_drop
);

  localparam int unsigned CntW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {StHdr, StData, StGap} state_e;

  state_e          state_q, state_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [1:0]      hdr_q, hdr_d;
  logic [CntW-1:0] pay_cnt_q, pay_cnt_d;
  logic            en_q, en_d;
  logic [2:0]      sel_q, sel_d;
  logic            dout_q, dout_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic            accept;
  logic [2:0]      hdr_sel;

  assign s_ready = (state_q != StGap);
  assign accept  = s_valid & s_ready;
  assign hdr_sel = {hdr_q, s_data};

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
    pay_cnt_d = pay_cnt_q;
    en_d      = en_q;
    sel_d     = sel_q;
    // Payload outputs are single-cycle: anything not refreshed by an accept drops to 0.
    dout_d    = 1'b0;
    active_d  = 1'b0;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          if (hdr_cnt_q == 2'd2) begin
            sel_d     = hdr_sel;
            en_d      = chan_mask[hdr_sel];
            pay_cnt_d = '0;
            hdr_cnt_d = 2'd0;
            state_d   = StData;
          end else begin
            hdr_d     = {hdr_q[0], s_data};
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end
      end
      StData: begin
        if (accept) begin
          dout_d    = s_data & en_q;
          active_d  = en_q;
          pay_cnt_d = pay_cnt_q + CntW'(1);
          if (pay_cnt_q == LastCnt) begin
            done_d  = en_q;
            drop_d  = ~en_q;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        hdr_cnt_d = 2'd0;
        state_d   = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHdr;
      hdr_cnt_q <= 2'd0;
      hdr_q     <= 2'd0;
      pay_cnt_q <= '0;
      en_q      <= 1'b0;
      sel_q     <= 3'd0;
      dout_q    <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      hdr_q     <= hdr_d;
      pay_cnt_q <= pay_cnt_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      active_q  <= active_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign active     = active_q;
  assign frame_done = done_q;
  assign frame_drop = drop_q;

endmodule
